cobra_out_tracer: RTL and testbench
===================================

Name: cobra_out_tracer

Overview:
- Parametrised capture buffer that sits beside the CYBERcobra core. It watches the core's out_o bus and records every value change together with a cycle timestamp.
- Entries are held in a DEPTH-deep circular buffer and drained through a valid/ready read port. This lets benches and on-board debug logic read back counter and program traces instead of inspecting waveforms.
- Generalises the single-bus observation to configurable data width, depth, timestamp width and full-buffer mode.

Parameters:
- DATA_W, 32, width of the observed bus and of stored data.
- DEPTH, 16, number of buffer entries; power of two, >= 2.
- TS_W, 16, timestamp counter width.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- sample_i  in  DATA_W  observed bus (core out_o).
- en_i  in  1  capture and timestamp enable.
- mode_i  in  1  0 = stop-when-full, 1 = wrap (overwrite oldest).
- clear_i  in  1  synchronous flush.
- rd_valid_o  out  1  buffer holds at least one entry.
- rd_ready_i  in  1  consumer accepts the head entry.
- rd_data_o  out  DATA_W  head entry data.
- rd_ts_o  out  TS_W  head entry timestamp.
- count_o  out  $clog2(DEPTH)+1  number of stored entries.
- overflow_o  out  1  sticky flag: an entry was dropped or overwritten.

Behaviour:
- Reset (rst_i=1 at a clock edge): wr_ptr, rd_ptr, count and timestamp counter go to 0; overflow_o=0; the has_prev flag is cleared. Outputs are then rd_valid_o=0, rd_data_o=0, rd_ts_o=0, count_o=0. Reset overrides all other inputs, including mid-capture and mid-read.
- clear_i=1 (no reset): identical effect to reset. It has priority over any push or pop in the same cycle.
- Timestamp: ts increments by 1 each cycle with en_i=1 and wraps modulo 2^TS_W. It holds while en_i=0.
- Capture condition, evaluated at the edge: en_i=1 and (has_prev=0 or sample_i != prev).
  - prev is updated to sample_i every cycle with en_i=1; has_prev is set to 1 on that edge.
  - The first enabled cycle after reset or clear therefore always captures.
- Stored entry = {sample_i, ts value before the increment on that edge}.
- Latency: a capture at edge t into an empty buffer gives rd_valid_o=1 and the entry on rd_data_o/rd_ts_o from t onward, i.e. one cycle after sample_i was presented.
- Read port:
  - rd_valid_o = (count != 0), driven from registers only, with no combinational path from rd_ready_i.
  - rd_data_o/rd_ts_o are the entry at rd_ptr when valid, and 0 when empty.
  - Pop occurs on rd_valid_o && rd_ready_i. rd_ready_i is ignored when the buffer is empty.
- Push and pop in the same cycle, with the buffer non-empty and not full: both take effect and count is unchanged.
- Full (count = DEPTH), push requested:
  - Simultaneous pop: the push is accepted in the slot freed that cycle; count stays DEPTH; no overflow.
  - mode_i=0, no pop: the sample is dropped, overflow_o is set, and the buffer is unchanged.
  - mode_i=1, no pop: the oldest entry is overwritten; wr_ptr and rd_ptr both advance; count stays DEPTH; overflow_o is set.
- Pointers wrap modulo DEPTH.
- mode_i may change at any time and applies from the next edge.
- overflow_o clears only on reset or clear_i.
- Only the enabled capture path can set overflow_o.

Test Plan:
- Reset, then en_i=1 with sample_i held at 0x0 for 5 cycles -> exactly one entry {0x0, ts 0}; count_o=1; rd_valid_o=1 on the cycle after the first sample.
- Counter emulation: sample_i steps 0,1,2,…,0xE5 with each value held 3 cycles, rd_ready_i=0, DEPTH=16, mode 0 -> count_o=16; entries 0..15 with timestamps 0,3,6,…,45; overflow_o=1.
- Same stimulus with mode 1 -> count_o=16; head data 0xD6 (last 16 values 0xD6..0xE5); overflow_o=1; draining yields 0xD6..0xE5 in order.
- Full buffer in mode 0, push and pop in the same cycle -> new value accepted at the tail; count_o stays 16; overflow_o remains 0 if it was previously clear.
- Continuous change with rd_ready_i=1 every cycle -> count_o never exceeds 1; every value is read exactly once, in order, with timestamps increasing by 1.
- Assert clear_i while full with overflow_o=1, at the same time as a push and a pop -> next cycle count_o=0, rd_valid_o=0, overflow_o=0, and ts restarts at 0. Repeat the scenario with rst_i instead of clear_i and expect identical results.

Source files
------------

// File: rtl/cobra_out_tracer.sv
// Change-capture trace buffer for the CYBERcobra out_o bus: records each new
// value with a cycle timestamp in a circular buffer drained via valid/ready.
module cobra_out_tracer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        sample_i,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic                     clear_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [TS_W-1:0]          rd_ts_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] prev;
  logic              has_prev;
  logic              overflow;

  logic capture, pop, full, push_ok, overwrite, drop, mem_we, rd_adv, flush;

  always_comb begin
    flush     = rst_i || clear_i;
    full      = (count == FULL_CNT);
    capture   = en_i && (!has_prev || (sample_i != prev));
    pop       = (count != '0) && rd_ready_i;
    // A pop on a full buffer frees the slot at wr_ptr, so the push still lands.
    push_ok   = capture && (!full || pop);
    overwrite = capture && full && !pop && mode_i;
    drop      = capture && full && !pop && !mode_i;
    mem_we    = push_ok || overwrite;
    rd_adv    = pop || overwrite;
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      prev     <= '0;
      has_prev <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (en_i) begin
        ts       <= ts + 1'b1;
        prev     <= sample_i;
        has_prev <= 1'b1;
      end
      if (mem_we) wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (drop || overwrite) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the read side is gated by count.
  always_ff @(posedge clk_i) begin
    if (mem_we && !flush) mem[wr_ptr] <= '{data: sample_i, ts: ts};
  end

  always_comb begin
    rd_valid_o = (count != '0);
    rd_data_o  = rd_valid_o ? mem[rd_ptr].data : '0;
    rd_ts_o    = rd_valid_o ? mem[rd_ptr].ts   : '0;
    count_o    = count;
    overflow_o = overflow;
  end

endmodule

// File: tb/tb_cobra_out_tracer.sv
// Directed bench for cobra_out_tracer with hand-derived expectations.
module tb_cobra_out_tracer;
  localparam int DATA_W = 32, DEPTH = 16, TS_W = 16;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0, en_i = 1'b0, mode_i = 1'b0, clear_i = 1'b0, rd_ready_i = 1'b0;
  logic [DATA_W-1:0] sample_i = '0;
  logic              rd_valid_o, overflow_o;
  logic [DATA_W-1:0] rd_data_o;
  logic [TS_W-1:0]   rd_ts_o;
  logic [4:0]        count_o;

  int n_cmp = 0, n_bad = 0;

  cobra_out_tracer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .sample_i(sample_i), .en_i(en_i), .mode_i(mode_i),
    .clear_i(clear_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o), .rd_ts_o(rd_ts_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    en_i = 1'b0; rd_ready_i = 1'b0; clear_i = 1'b0; mode_i = 1'b0;
  endtask

  task automatic test_reset();
    en_i = 1'b1; sample_i = 32'h1234; rd_ready_i = 1'b1;
    rst_i = 1'b1; tick(); rst_i = 1'b0; en_i = 1'b0; rd_ready_i = 1'b0;
    n_cmp++; if (rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", rd_valid_o); end
    n_cmp++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_cmp++; if (rd_data_o !== 32'h0 || rd_ts_o !== 16'h0) begin n_bad++; $display("FAIL reset_data got %h/%h want 0/0", rd_data_o, rd_ts_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
  endtask

  task automatic test_hold_value();
    do_reset();
    en_i = 1'b1; sample_i = 32'h0;
    tick();
    n_cmp++; if (rd_valid_o !== 1'b1) begin n_bad++; $display("FAIL hold_first_valid got %b want 1", rd_valid_o); end
    for (int i = 0; i < 4; i++) tick();
    en_i = 1'b0;
    n_cmp++; if (count_o !== 5'd1) begin n_bad++; $display("FAIL hold_count got %0d want 1", count_o); end
    n_cmp++; if (rd_data_o !== 32'h0 || rd_ts_o !== 16'd0) begin n_bad++; $display("FAIL hold_entry got %h/%0d want 0/0", rd_data_o, rd_ts_o); end
  endtask

  task automatic test_counter(input logic mode);
    logic [31:0] base;
    do_reset();
    mode_i = mode; en_i = 1'b1;
    for (int v = 0; v <= 32'hE5; v++)
      for (int r = 0; r < 3; r++) begin sample_i = 32'(v); tick(); end
    en_i = 1'b0;
    base = mode ? 32'hD6 : 32'h0;
    n_cmp++; if (count_o !== 5'd16) begin n_bad++; $display("FAIL counter_m%0d_count got %0d want 16", mode, count_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL counter_m%0d_ovf got %b want 1", mode, overflow_o); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== base + 32'(i) || rd_ts_o !== 16'(3 * (base + 32'(i)))) begin
        n_bad++; $display("FAIL counter_m%0d_drain%0d got v%b %h/%0d want %h/%0d", mode, i, rd_valid_o,
                          rd_data_o, rd_ts_o, base + 32'(i), 3 * (base + 32'(i)));
      end
      rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0;
    end
    n_cmp++; if (rd_valid_o !== 1'b0 || count_o !== 5'd0) begin n_bad++; $display("FAIL counter_m%0d_empty got v%b c%0d want v0 c0", mode, rd_valid_o, count_o); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin sample_i = 32'h50 + 32'(i); tick(); end
    n_cmp++; if (count_o !== 5'd16 || overflow_o !== 1'b0) begin n_bad++; $display("FAIL fpp_fill got c%0d o%b want c16 o0", count_o, overflow_o); end
    sample_i = 32'h77; rd_ready_i = 1'b1; tick(); rd_ready_i = 1'b0; en_i = 1'b0;
    n_cmp++; if (count_o !== 5'd16 || overflow_o !== 1'b0) begin n_bad++; $display("FAIL fpp_after got c%0d o%b want c16 o0", count_o, overflow_o); end
    n_cmp++; if (rd_data_o !== 32'h51 || rd_ts_o !== 16'd1) begin n_bad++; $display("FAIL fpp_head got %h/%0d want 51/1", rd_data_o, rd_ts_o); end
    rd_ready_i = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    rd_ready_i = 1'b0;
    n_cmp++; if (count_o !== 5'd1 || rd_data_o !== 32'h77 || rd_ts_o !== 16'd16) begin n_bad++; $display("FAIL fpp_tail got c%0d %h/%0d want c1 77/16", count_o, rd_data_o, rd_ts_o); end
  endtask

  task automatic test_back_to_back();
    int bad_here;
    bad_here = 0;
    do_reset();
    en_i = 1'b1; rd_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample_i = 32'h100 + 32'(i); tick();
      n_cmp++;
      if (count_o > 5'd1 || rd_valid_o !== 1'b1 || rd_data_o !== 32'h100 + 32'(i) || rd_ts_o !== 16'(i)) begin
        n_bad++; $display("FAIL b2b_%0d got c%0d v%b %h/%0d want c1 %h/%0d", i, count_o, rd_valid_o,
                          rd_data_o, rd_ts_o, 32'h100 + 32'(i), i);
      end
    end
    en_i = 1'b0; tick(); rd_ready_i = 1'b0;
    n_cmp++; if (count_o !== 5'd0 || rd_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got c%0d v%b want c0 v0", count_o, rd_valid_o); end
  endtask

  task automatic test_flush(input logic use_rst);
    do_reset();
    en_i = 1'b1;
    for (int i = 0; i < 17; i++) begin sample_i = 32'h20 + 32'(i); tick(); end
    n_cmp++; if (count_o !== 5'd16 || overflow_o !== 1'b1) begin n_bad++; $display("FAIL flush%0d_pre got c%0d o%b want c16 o1", use_rst, count_o, overflow_o); end
    sample_i = 32'h99; rd_ready_i = 1'b1;
    if (use_rst) rst_i = 1'b1; else clear_i = 1'b1;
    tick();
    rst_i = 1'b0; clear_i = 1'b0; rd_ready_i = 1'b0; en_i = 1'b0;
    n_cmp++;
    if (count_o !== 5'd0 || rd_valid_o !== 1'b0 || overflow_o !== 1'b0 || rd_data_o !== 32'h0) begin
      n_bad++; $display("FAIL flush%0d_post got c%0d v%b o%b d%h want c0 v0 o0 d0", use_rst, count_o, rd_valid_o, overflow_o, rd_data_o);
    end
    en_i = 1'b1; tick(); en_i = 1'b0;
    n_cmp++; if (count_o !== 5'd1 || rd_data_o !== 32'h99 || rd_ts_o !== 16'd0) begin n_bad++; $display("FAIL flush%0d_restart got c%0d %h/%0d want c1 99/0", use_rst, count_o, rd_data_o, rd_ts_o); end
  endtask

  initial begin
    test_reset();
    test_hold_value();
    test_counter(1'b0);
    test_counter(1'b1);
    test_full_push_pop();
    test_back_to_back();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
